// File: rtl/ttl74169_v.sv
// ttl74169_v -- synchronous presettable up/down binary counter, 74169 style.
//
// The down direction can optionally reload from D when it reaches zero
// instead of wrapping. This lets the block run as a programmable
// divide-by-(D+1) timer. Stages cascade by wiring TC_o of the lower stage
// into CET_i of the next stage. CEP_i is shared across all stages.
//
// Ports:
//   CP_i   clock, rising edge
//   MR_i   master reset, asynchronous, active-high; forces Q_o to 0
//   PEn_i  synchronous parallel load, active-low (highest sync priority)
//   D_i    load / reload data (MSB = QD side)
//   CEP_i  count enable parallel, active-high
//   CET_i  count enable trickle, active-high; also gates TC_o
//   U_D_i  direction: 1 = up, 0 = down
//   ARL_i  auto-reload from D_i on down count at zero, active-high
//   Q_o    counter state
//   TC_o   terminal count, combinational
module ttl74169_v #(
  parameter int WIDTH = 4
) (
  input  logic             CP_i,
  input  logic             MR_i,
  input  logic             PEn_i,
  input  logic [WIDTH-1:0] D_i,
  input  logic             CEP_i,
  input  logic             CET_i,
  input  logic             U_D_i,
  input  logic             ARL_i,
  output logic [WIDTH-1:0] Q_o,
  output logic             TC_o
);

  // Operation selected for the coming edge. Naming each case keeps the
  // priority order readable and confines D_i sampling to two cases.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN,
    OP_RELOAD,
    OP_WRAP
  } op_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  op_e              op;
  logic             q_zero, q_ones, cnt_en;

  assign q_zero = (q_q == ZERO);
  assign q_ones = (q_q == ALL_ONES);
  assign cnt_en = CEP_i & CET_i;

  // Decode priority: load, then count (if both enables), else hold.
  always_comb begin
    op = OP_HOLD;
    if (!PEn_i)             op = OP_LOAD;
    else if (cnt_en) begin
      if (U_D_i)            op = OP_UP;
      else if (!q_zero)     op = OP_DOWN;
      else if (ARL_i)       op = OP_RELOAD;
      else                  op = OP_WRAP;
    end
  end

  // D_i is only routed to q_d on load/reload. An X on D_i on any other
  // edge therefore never reaches the register.
  always_comb begin
    q_d = q_q;
    case (op)
      OP_LOAD,
      OP_RELOAD: q_d = D_i;
      OP_UP:     q_d = q_q + ONE;   // all-ones wraps to zero naturally
      OP_DOWN:   q_d = q_q - ONE;
      OP_WRAP:   q_d = ALL_ONES;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge CP_i or posedge MR_i) begin
    if (MR_i) q_q <= ZERO;
    else      q_q <= q_d;
  end

  assign Q_o = q_q;

  // Terminal count depends on direction and CET only. It ignores CEP and
  // PEn so that a cascade sees the lower stage's position even when that
  // stage is paused or being loaded.
  assign TC_o = CET_i & ((U_D_i & q_ones) | (~U_D_i & q_zero));

endmodule
